// File: rtl/sr_reg_arbiter.sv
// Round-robin arbiter committing one requester's set/clear masks per cycle into a shared flag register.
// Optional SR_ARB_TOGGLE_EN: s=r=1 toggles the bit, and conflict reporting is tied off.
module sr_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] set_mask,
  input  logic [NREQ*WIDTH-1:0] clr_mask,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  conflict,
  output logic [7:0]            conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    ptr_nxt;
  logic [NREQ-1:0]  elig;
  logic             found;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_nxt;

  // gnt doubles as the last-winner mask: both are one-hot(w) or zero
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    s       = set_mask[int'(win)*WIDTH +: WIDTH];
    r       = clr_mask[int'(win)*WIDTH +: WIDTH];
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`ifdef SR_ARB_TOGGLE_EN
    q_nxt   = (q & ~(s | r)) | (s & ~r) | (~q & s & r);
`else
    q_nxt   = (q & ~(s ^ r)) | (s & ~r);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      gnt <= '0;
      q   <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
      gnt <= NREQ'(1) << win;
      q   <= q_nxt;
    end else begin
      gnt <= '0;
    end
  end

`ifdef SR_ARB_TOGGLE_EN
  assign conflict     = 1'b0;
  assign conflict_cnt = '0;
`else
  logic hit;

  assign hit = found && (|(s & r));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= hit;
      if (hit && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/sr_reg_arbiter.md
# sr_reg_arbiter

Round-robin arbiter sharing a single WIDTH-bit set/reset flag register among NREQ requesters. Each requester presents per-bit set and clear masks; the granted requester's masks are applied to the register with SR flip-flop semantics in one clock. It sits in front of the shared status/flag register bank, so multiple agents can set or clear individual flags without read-modify-write races.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the shared flag register
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request; held until its grant bit pulses
- set_mask  input  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- clr_mask  input  NREQ*WIDTH  same packing as set_mask
- gnt  output  NREQ  one-hot, registered; one-cycle pulse marking the commit of that requester's masks
- q  output  WIDTH  shared flag register
- conflict  output  1  registered one-cycle pulse: committed op had at least one bit with set and clear both high
- conflict_cnt  output  8  saturating count of conflict pulses

## Operation
- Reset (reset low, asynchronous): q=0, gnt=0, conflict=0, conflict_cnt=0, round-robin pointer ptr=0, last-winner mask=0.
- Arbitration each cycle over eligible = req & ~last_gnt (requester granted at the previous edge is excluded for exactly one cycle; this prevents double commit while it drops req).
- Winner = first eligible index searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrap-around).
- On the edge with a winner w: gnt <= one-hot(w); ptr <= (w+1) mod NREQ; q updated from masks of w; last_gnt <= one-hot(w).
- No eligible requester: gnt <= 0, ptr and q hold, last_gnt <= 0.
- Per-bit update of q from (s,r) = (set_mask[w][b], clr_mask[w][b]): 00 hold, 10 set to 1, 01 clear to 0, 11 per Configuration.
- conflict asserted on the same edge as gnt when any bit of the committed op has s=r=1; conflict_cnt increments then, saturates at 255.
- req deasserted before grant: request is withdrawn, nothing committed.
- Masks are sampled only on the arbitration edge; requester must hold them stable while req high.

## Timing
- Latency: req high before edge k (and eligible) -> gnt and updated q visible after edge k (one cycle).
- Maximum throughput one commit per cycle; a single persistent requester commits every other cycle.
- With all NREQ requesting continuously, each is granted exactly once per NREQ cycles.
- Reset mid-operation: outputs clear immediately on reset falling, independent of clk; first grant possible on first rising edge after reset rises.

## Configuration
- SR_ARB_TOGGLE_EN defined: s=r=1 toggles the bit (JK behaviour); conflict and conflict_cnt are tied to 0.
- SR_ARB_TOGGLE_EN undefined: s=r=1 holds the bit value (never X), conflict pulses, conflict_cnt counts.

## Test plan
- Reset: drive reset low mid-run with q=8'hA5 -> q=0, gnt=0, conflict_cnt=0 immediately, without a clock edge.
- Single requester: req=4'b0001, set_mask[0]=8'h0F held -> gnt=0001 after edge 1, q=8'h0F; no gnt at edge 2; gnt again at edge 3.
- Round robin: req=4'b1111 continuously -> gnt sequence 0001,0010,0100,1000,0001; ptr wraps.
- Set/clear: q=8'hFF, requester 2 clr_mask=8'hF0 -> q=8'h0F after its grant; other requesters' masks ignored that cycle.
- Conflict (macro off): q=8'h00, set=clr=8'h01 -> q stays 8'h00, conflict pulse, conflict_cnt=1; 300 conflicts -> conflict_cnt=255.
- Toggle (macro on): q=8'h00, set=clr=8'h03 -> q=8'h03, repeat -> q=8'h00, conflict stays 0.
